// File: rtl/tlb_op_sequencer.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR against a single-read-port TLB array and owns cp0 Random.
// Optional: define TLB_MULTIHIT_EN for a full probe scan with a multihit_o pulse.
module tlb_op_sequencer #(
  parameter int TLB_ENTRIES = 32,
  parameter int IDX_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid_i,
  input  logic [1:0]       op_type_i,
  input  logic             flush_i,
  input  logic [31:0]      cp0_entryHi_i,
  input  logic [31:0]      cp0_pageMask_i,
  input  logic [31:0]      cp0_entryLo0_i,
  input  logic [31:0]      cp0_entryLo1_i,
  input  logic [31:0]      cp0_index_i,
  input  logic [31:0]      cp0_wired_i,
  output logic             tlb_rd_en_o,
  output logic [IDX_W-1:0] tlb_rd_idx_o,
  input  logic [31:0]      tlb_rd_hi_i,
  input  logic [31:0]      tlb_rd_mask_i,
  input  logic [31:0]      tlb_rd_lo0_i,
  input  logic [31:0]      tlb_rd_lo1_i,
  output logic             tlb_we_o,
  output logic [IDX_W-1:0] tlb_w_idx_o,
  output logic [31:0]      tlb_w_hi_o,
  output logic [31:0]      tlb_w_mask_o,
  output logic [31:0]      tlb_w_lo0_o,
  output logic [31:0]      tlb_w_lo1_o,
  output logic [2:0]       tlb_type_o,
  output logic [31:0]      tlb_entryHi_o,
  output logic [31:0]      tlb_pageMask_o,
  output logic [31:0]      tlb_entryLo0_o,
  output logic [31:0]      tlb_entryLo1_o,
  output logic [31:0]      tlb_index_o,
  output logic [IDX_W-1:0] random_o,
  output logic             op_done_o,
  output logic             op_stall_o
`ifdef TLB_MULTIHIT_EN
  ,
  output logic             multihit_o
`endif
);

  localparam logic [IDX_W:0]   LP_N    = (IDX_W+1)'(TLB_ENTRIES);
  localparam logic [IDX_W-1:0] LP_LAST = IDX_W'(TLB_ENTRIES - 1);
  localparam logic [31:0]      LP_MISS = 32'h8000_0000;

  typedef enum logic [1:0] {ST_IDLE, ST_PROBE, ST_READ, ST_WRITE} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W:0]   r_cnt, w_cnt_nxt, w_cnt_m1;
  logic [IDX_W-1:0] r_w_idx, w_w_idx_nxt, w_cmp_idx;
  logic [IDX_W-1:0] r_random;
  logic [31:0]      r_entryHi, r_pageMask, r_entryLo0, r_entryLo1, r_index;
  logic [31:0]      r_w_hi, r_w_mask, r_w_lo0, r_w_lo1;
  logic [31:0]      w_new_index, w_rd_hi_clr, w_wr_hi, w_wr_mask;
  logic [18:0]      w_vpn_keep;
  logic             w_match, w_last, w_ld_idx, w_ld_hi, w_we, w_done;
  logic             w_unused;
`ifdef TLB_MULTIHIT_EN
  logic             r_found, w_found_nxt;
  logic [IDX_W-1:0] r_hit_idx, w_hit_idx_nxt;
  logic             r_multi, w_multi_nxt, w_multihit;
`endif

  // Entry k-1 is compared while r_cnt==k, since read data lags the index by a cycle.
  assign w_cnt_m1   = r_cnt - 1'b1;
  assign w_cmp_idx  = w_cnt_m1[IDX_W-1:0];
  assign w_last     = (r_cnt == LP_N);
  assign w_vpn_keep = ~tlb_rd_mask_i[31:13];
  assign w_match    = ((tlb_rd_hi_i[31:13] & w_vpn_keep) == (cp0_entryHi_i[31:13] & w_vpn_keep))
                    && (tlb_rd_hi_i[12] || (tlb_rd_hi_i[7:0] == cp0_entryHi_i[7:0]));

  assign w_rd_hi_clr = tlb_rd_hi_i & ~32'h0000_1000;
  assign w_wr_hi     = {cp0_entryHi_i[31:13] & ~cp0_pageMask_i[31:13],
                        cp0_entryLo0_i[0] & cp0_entryLo1_i[0], 4'b0000, cp0_entryHi_i[7:0]};
  assign w_wr_mask   = cp0_pageMask_i & 32'hFFFF_E000;
  assign w_unused    = ^{cp0_index_i[31:IDX_W], cp0_entryHi_i[12:8]};

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_w_idx_nxt  = r_w_idx;
    tlb_rd_en_o  = 1'b0;
    tlb_rd_idx_o = '0;
    w_we         = 1'b0;
    w_ld_idx     = 1'b0;
    w_ld_hi      = 1'b0;
    w_done       = 1'b0;
    w_new_index  = '0;
`ifdef TLB_MULTIHIT_EN
    w_found_nxt   = r_found;
    w_hit_idx_nxt = r_hit_idx;
    w_multi_nxt   = r_multi;
    w_multihit    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (op_valid_i && !flush_i) begin
          case (op_type_i)
            2'd0: begin
              tlb_rd_en_o = 1'b1;
              w_cnt_nxt   = (IDX_W+1)'(1);
              w_state_nxt = ST_PROBE;
`ifdef TLB_MULTIHIT_EN
              w_found_nxt = 1'b0;
              w_multi_nxt = 1'b0;
`endif
            end
            2'd1: begin
              tlb_rd_en_o  = 1'b1;
              tlb_rd_idx_o = cp0_index_i[IDX_W-1:0];
              w_state_nxt  = ST_READ;
            end
            2'd2: begin
              w_w_idx_nxt = cp0_index_i[IDX_W-1:0];
              w_state_nxt = ST_WRITE;
            end
            default: begin
              w_w_idx_nxt = r_random;
              w_state_nxt = ST_WRITE;
            end
          endcase
        end
      end
      ST_PROBE: begin
        if (flush_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
`ifdef TLB_MULTIHIT_EN
          if (w_last) begin
            w_ld_idx    = 1'b1;
            w_done      = 1'b1;
            w_multihit  = r_multi | (r_found & w_match);
            w_new_index = r_found ? 32'(r_hit_idx) : (w_match ? 32'(w_cmp_idx) : LP_MISS);
            w_state_nxt = ST_IDLE;
          end else begin
            tlb_rd_en_o  = 1'b1;
            tlb_rd_idx_o = r_cnt[IDX_W-1:0];
            w_cnt_nxt    = r_cnt + 1'b1;
            if (w_match) begin
              if (r_found) begin
                w_multi_nxt = 1'b1;
              end else begin
                w_found_nxt   = 1'b1;
                w_hit_idx_nxt = w_cmp_idx;
              end
            end
          end
`else
          if (w_match || w_last) begin
            w_ld_idx    = 1'b1;
            w_done      = 1'b1;
            w_new_index = w_match ? 32'(w_cmp_idx) : LP_MISS;
            w_state_nxt = ST_IDLE;
          end else begin
            tlb_rd_en_o  = 1'b1;
            tlb_rd_idx_o = r_cnt[IDX_W-1:0];
            w_cnt_nxt    = r_cnt + 1'b1;
          end
`endif
        end
      end
      ST_READ: begin
        if (!flush_i) begin
          w_ld_hi = 1'b1;
          w_done  = 1'b1;
        end
        w_state_nxt = ST_IDLE;
      end
      ST_WRITE: begin
        if (!flush_i) begin
          w_we   = 1'b1;
          w_done = 1'b1;
        end
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_w_idx    <= '0;
      r_index    <= '0;
      r_entryHi  <= '0;
      r_pageMask <= '0;
      r_entryLo0 <= '0;
      r_entryLo1 <= '0;
      r_w_hi     <= '0;
      r_w_mask   <= '0;
      r_w_lo0    <= '0;
      r_w_lo1    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_w_idx <= w_w_idx_nxt;
      if (w_ld_idx) r_index <= w_new_index;
      if (w_ld_hi) begin
        r_entryHi  <= w_rd_hi_clr;
        r_pageMask <= tlb_rd_mask_i;
        r_entryLo0 <= tlb_rd_lo0_i;
        r_entryLo1 <= tlb_rd_lo1_i;
      end
      if (w_we) begin
        r_w_hi   <= w_wr_hi;
        r_w_mask <= w_wr_mask;
        r_w_lo0  <= cp0_entryLo0_i;
        r_w_lo1  <= cp0_entryLo1_i;
      end
    end
  end

`ifdef TLB_MULTIHIT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_found   <= 1'b0;
      r_hit_idx <= '0;
      r_multi   <= 1'b0;
    end else begin
      r_found   <= w_found_nxt;
      r_hit_idx <= w_hit_idx_nxt;
      r_multi   <= w_multi_nxt;
    end
  end

  assign multihit_o = w_multihit;
`endif

  // A Wired value at or above TLB_ENTRIES always satisfies the compare, pinning Random at the top.
  always_ff @(posedge clk) begin
    if (rst)                                r_random <= LP_LAST;
    else if (32'(r_random) <= cp0_wired_i)  r_random <= LP_LAST;
    else                                    r_random <= r_random - 1'b1;
  end

  // Completion-cycle values bypass the hold registers so cp0 sees them in the done cycle.
  assign tlb_index_o    = w_ld_idx ? w_new_index    : r_index;
  assign tlb_entryHi_o  = w_ld_hi  ? w_rd_hi_clr    : r_entryHi;
  assign tlb_pageMask_o = w_ld_hi  ? tlb_rd_mask_i  : r_pageMask;
  assign tlb_entryLo0_o = w_ld_hi  ? tlb_rd_lo0_i   : r_entryLo0;
  assign tlb_entryLo1_o = w_ld_hi  ? tlb_rd_lo1_i   : r_entryLo1;
  assign tlb_w_hi_o     = w_we     ? w_wr_hi        : r_w_hi;
  assign tlb_w_mask_o   = w_we     ? w_wr_mask      : r_w_mask;
  assign tlb_w_lo0_o    = w_we     ? cp0_entryLo0_i : r_w_lo0;
  assign tlb_w_lo1_o    = w_we     ? cp0_entryLo1_i : r_w_lo1;
  assign tlb_w_idx_o    = r_w_idx;
  assign tlb_we_o       = w_we;
  assign tlb_type_o     = {1'b0, w_ld_hi, w_ld_idx};
  assign op_done_o      = w_done;
  assign random_o       = r_random;
  assign op_stall_o     = (op_valid_i | (r_state != ST_IDLE)) & ~w_done;

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Directed self-checking bench for tlb_op_sequencer with a registered-read TLB array model.
module tb_tlb_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid_i, flush_i;
  logic [1:0]  op_type_i;
  logic [31:0] cp0_entryHi_i, cp0_pageMask_i, cp0_entryLo0_i, cp0_entryLo1_i;
  logic [31:0] cp0_index_i, cp0_wired_i;
  logic        tlb_rd_en_o, tlb_we_o, op_done_o, op_stall_o;
  logic [4:0]  tlb_rd_idx_o, tlb_w_idx_o, random_o;
  logic [31:0] tlb_rd_hi_i, tlb_rd_mask_i, tlb_rd_lo0_i, tlb_rd_lo1_i;
  logic [31:0] tlb_w_hi_o, tlb_w_mask_o, tlb_w_lo0_o, tlb_w_lo1_o;
  logic [2:0]  tlb_type_o;
  logic [31:0] tlb_entryHi_o, tlb_pageMask_o, tlb_entryLo0_o, tlb_entryLo1_o, tlb_index_o;
  logic        multihit_w;

  logic [31:0] m_hi [32];
  logic [31:0] m_mask [32];
  logic [31:0] m_lo0 [32];
  logic [31:0] m_lo1 [32];

  int n_checks = 0;
  int n_fail   = 0;

  int          cap_k;
  logic [2:0]  cap_type;
  logic [31:0] cap_index, cap_hi, cap_mask, cap_lo0, cap_lo1;
  logic [31:0] cap_whi, cap_wmask, cap_wlo0, cap_wlo1;
  logic [4:0]  cap_widx, cap_rd_idx0;
  logic        cap_we, cap_rd_en0, cap_stall, cap_mh;

  tlb_op_sequencer #(.TLB_ENTRIES(32), .IDX_W(5)) dut (
    .clk(clk), .rst(rst), .op_valid_i(op_valid_i), .op_type_i(op_type_i), .flush_i(flush_i),
    .cp0_entryHi_i(cp0_entryHi_i), .cp0_pageMask_i(cp0_pageMask_i),
    .cp0_entryLo0_i(cp0_entryLo0_i), .cp0_entryLo1_i(cp0_entryLo1_i),
    .cp0_index_i(cp0_index_i), .cp0_wired_i(cp0_wired_i),
    .tlb_rd_en_o(tlb_rd_en_o), .tlb_rd_idx_o(tlb_rd_idx_o),
    .tlb_rd_hi_i(tlb_rd_hi_i), .tlb_rd_mask_i(tlb_rd_mask_i),
    .tlb_rd_lo0_i(tlb_rd_lo0_i), .tlb_rd_lo1_i(tlb_rd_lo1_i),
    .tlb_we_o(tlb_we_o), .tlb_w_idx_o(tlb_w_idx_o),
    .tlb_w_hi_o(tlb_w_hi_o), .tlb_w_mask_o(tlb_w_mask_o),
    .tlb_w_lo0_o(tlb_w_lo0_o), .tlb_w_lo1_o(tlb_w_lo1_o),
    .tlb_type_o(tlb_type_o), .tlb_entryHi_o(tlb_entryHi_o), .tlb_pageMask_o(tlb_pageMask_o),
    .tlb_entryLo0_o(tlb_entryLo0_o), .tlb_entryLo1_o(tlb_entryLo1_o), .tlb_index_o(tlb_index_o),
    .random_o(random_o), .op_done_o(op_done_o), .op_stall_o(op_stall_o)
`ifdef TLB_MULTIHIT_EN
    , .multihit_o(multihit_w)
`endif
  );

`ifndef TLB_MULTIHIT_EN
  assign multihit_w = 1'b0;
`endif

  always #5 clk = ~clk;

  // Array model: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (tlb_rd_en_o) begin
      tlb_rd_hi_i   <= m_hi[tlb_rd_idx_o];
      tlb_rd_mask_i <= m_mask[tlb_rd_idx_o];
      tlb_rd_lo0_i  <= m_lo0[tlb_rd_idx_o];
      tlb_rd_lo1_i  <= m_lo1[tlb_rd_idx_o];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_default();
    for (int i = 0; i < 32; i++) begin
      m_hi[i]   = 32'h1000_0000 + (i << 13) + 32'h55;
      m_mask[i] = 32'h0;
      m_lo0[i]  = i;
      m_lo1[i]  = i + 100;
    end
  endtask

  // Hand-derived done offset: first hit j finishes at T+j+1, or T+32 with a full scan.
  function automatic int exp_done(input int j);
`ifdef TLB_MULTIHIT_EN
    return 32;
`else
    return j + 1;
`endif
  endfunction

  task automatic run_op(input logic [1:0] typ, input int limit);
    op_type_i  = typ;
    op_valid_i = 1'b1;
    cap_k      = -1;
    for (int k = 0; k <= limit; k++) begin
      @(negedge clk);
      if (k == 0) begin
        cap_rd_en0  = tlb_rd_en_o;
        cap_rd_idx0 = tlb_rd_idx_o;
      end
      if (op_done_o) begin
        cap_k     = k;
        cap_type  = tlb_type_o;
        cap_index = tlb_index_o;
        cap_hi    = tlb_entryHi_o;
        cap_mask  = tlb_pageMask_o;
        cap_lo0   = tlb_entryLo0_o;
        cap_lo1   = tlb_entryLo1_o;
        cap_we    = tlb_we_o;
        cap_widx  = tlb_w_idx_o;
        cap_whi   = tlb_w_hi_o;
        cap_wmask = tlb_w_mask_o;
        cap_wlo0  = tlb_w_lo0_o;
        cap_wlo1  = tlb_w_lo1_o;
        cap_stall = op_stall_o;
        cap_mh    = multihit_w;
        break;
      end
      tick();
    end
    tick();
    op_valid_i = 1'b0;
  endtask

  initial begin
    logic [31:0] seen;
    logic        saw_done;
    rst = 1'b1; op_valid_i = 1'b0; op_type_i = 2'd0; flush_i = 1'b0;
    cp0_entryHi_i = '0; cp0_pageMask_i = '0; cp0_entryLo0_i = '0; cp0_entryLo1_i = '0;
    cp0_index_i = '0; cp0_wired_i = '0;
    tlb_rd_hi_i = '0; tlb_rd_mask_i = '0; tlb_rd_lo0_i = '0; tlb_rd_lo1_i = '0;
    fill_default();
    tick(); tick();
    @(negedge clk);
    check_val("rst_random", 32'(random_o), 32'd31);
    check_val("rst_strobes", {tlb_rd_en_o, tlb_we_o, op_done_o, op_stall_o, tlb_type_o}, 32'h0);
    check_val("rst_index", tlb_index_o, 32'h0);
    tick();
    rst = 1'b0;

    // Basic probe hit at entry 5 (ASID match)
    m_hi[5] = 32'h0040_2001;
    cp0_entryHi_i = 32'h0040_2001;
    run_op(2'd0, 40);
    check_val("p5_rd_at_T", {cap_rd_en0, 27'(cap_rd_idx0)}, {1'b1, 27'd0});
    check_val("p5_done_k", 32'(cap_k), 32'(exp_done(5)));
    check_val("p5_type", 32'(cap_type), 32'd1);
    check_val("p5_index", cap_index, 32'd5);
    check_val("p5_stall_done", 32'(cap_stall), 32'd0);

    // No hit anywhere
    cp0_entryHi_i = 32'h7777_E0AA;
    tick();
    run_op(2'd0, 40);
    check_val("miss_done_k", 32'(cap_k), 32'd32);
    check_val("miss_index", cap_index, 32'h8000_0000);
    check_val("miss_type", 32'(cap_type), 32'd1);

    // Global entry 3 with a different ASID wins over entry 5
    m_hi[3] = 32'h0040_3033;
    cp0_entryHi_i = 32'h0040_2001;
    tick();
    run_op(2'd0, 40);
    check_val("g3_done_k", 32'(cap_k), 32'(exp_done(3)));
    check_val("g3_index", cap_index, 32'd3);
    fill_default();

    // Hit only on the last entry
    cp0_entryHi_i = 32'h1003_E055;
    tick();
    run_op(2'd0, 40);
    check_val("last_done_k", 32'(cap_k), 32'd32);
    check_val("last_index", cap_index, 32'd31);

    // TLBR: index 0x27 wraps to entry 7, G bit cleared
    m_hi[7] = 32'h1234_F0AB; m_mask[7] = 32'h0001_E000;
    m_lo0[7] = 32'h0ABC_1235; m_lo1[7] = 32'h0DEF_4567;
    cp0_index_i = 32'h0000_0027;
    tick();
    run_op(2'd1, 4);
    check_val("rd_at_T", {cap_rd_en0, 27'(cap_rd_idx0)}, {1'b1, 27'd7});
    check_val("rd_done_k", 32'(cap_k), 32'd1);
    check_val("rd_type", 32'(cap_type), 32'd2);
    check_val("rd_hi", cap_hi, 32'h1234_E0AB);
    check_val("rd_mask", cap_mask, 32'h0001_E000);
    check_val("rd_lo0", cap_lo0, 32'h0ABC_1235);
    check_val("rd_lo1", cap_lo1, 32'h0DEF_4567);
    @(negedge clk);
    check_val("rd_hold_hi", tlb_entryHi_o, 32'h1234_E0AB);
    tick();

    // TLBWI with page mask and G formed from both Lo bits
    cp0_index_i = 32'd9; cp0_entryHi_i = 32'h00AB_E1FF; cp0_pageMask_i = 32'h0000_6000;
    cp0_entryLo0_i = 32'h0000_0007; cp0_entryLo1_i = 32'h0000_0003;
    run_op(2'd2, 4);
    check_val("wi_done_k", 32'(cap_k), 32'd1);
    check_val("wi_we_type", {cap_we, 28'd0, cap_type}, {1'b1, 31'd0});
    check_val("wi_idx", 32'(cap_widx), 32'd9);
    check_val("wi_hi", cap_whi, 32'h00AB_90FF);
    check_val("wi_mask", cap_wmask, 32'h0000_6000);
    check_val("wi_lo", {cap_wlo0[15:0], cap_wlo1[15:0]}, 32'h0007_0003);

    // TLBWR with wired=4: spacing of 3 cycles walks every Random value
    cp0_wired_i = 32'd4;
    repeat (40) tick();
    seen = '0;
    for (int n = 0; n < 64; n++) begin
      run_op(2'd3, 4);
      check_val("wr_in_range", {31'd0, (cap_k == 1) && cap_we && (cap_widx >= 5'd4)}, 32'd1);
      seen[cap_widx] = 1'b1;
      tick();
    end
    check_val("wr_cover", seen, 32'hFFFF_FFF0);

    cp0_wired_i = 32'd40;
    repeat (3) tick();
    run_op(2'd3, 4);
    check_val("wr_wired40_idx", 32'(cap_widx), 32'd31);
    @(negedge clk);
    check_val("wr_wired40_rand", 32'(random_o), 32'd31);
    tick();
    cp0_wired_i = 32'd0;

    // Flush at T+3 of a probe, then a TLBR is accepted at T+4
    saw_done = 1'b0;
    cp0_entryHi_i = 32'h7777_E0AA;
    op_type_i = 2'd0; op_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      saw_done |= op_done_o | (tlb_type_o != 3'd0);
      tick();
    end
    flush_i = 1'b1;
    @(negedge clk);
    saw_done |= op_done_o | (tlb_type_o != 3'd0);
    tick();
    flush_i = 1'b0; op_type_i = 2'd1; cp0_index_i = 32'd7;
    @(negedge clk);
    check_val("fl_no_done", 32'(saw_done), 32'd0);
    check_val("fl_accept_T4", {tlb_rd_en_o, 26'd0, tlb_rd_idx_o}, {1'b1, 26'd0, 5'd7});
    tick();
    @(negedge clk);
    check_val("fl_new_done", {op_done_o, 28'd0, tlb_type_o}, {1'b1, 28'd0, 3'd2});
    tick();
    op_valid_i = 1'b0;
    tick();

    // Synchronous reset at T+2 of a probe
    cp0_entryHi_i = 32'h7777_E0AA;
    op_type_i = 2'd0; op_valid_i = 1'b1;
    tick(); tick();
    rst = 1'b1; op_valid_i = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_val("rs_strobes", {tlb_rd_en_o, tlb_we_o, op_done_o, op_stall_o, tlb_type_o}, 32'h0);
    check_val("rs_data", tlb_index_o | tlb_entryHi_o | tlb_w_hi_o | 32'(tlb_w_idx_o), 32'h0);
    check_val("rs_random", 32'(random_o), 32'd31);
    tick();

    // Two matching entries, 2 and 9
    fill_default();
    m_hi[2] = 32'h0040_2001; m_hi[9] = 32'h0040_2001;
    cp0_entryHi_i = 32'h0040_2001;
    tick();
    run_op(2'd0, 40);
    check_val("mh_done_k", 32'(cap_k), 32'(exp_done(2)));
    check_val("mh_index", cap_index, 32'd2);
`ifdef TLB_MULTIHIT_EN
    check_val("mh_flag", 32'(cap_mh), 32'd1);
    m_hi[9] = m_hi[8] + 32'h0000_2000;
    tick();
    run_op(2'd0, 40);
    check_val("mh_single_flag", 32'(cap_mh), 32'd0);
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
